// File: rtl/pe_pkt_pkg.sv
// Packet field layout shared by pe_sink and pe_start-style injectors.
// Defaults describe the 32-bit, 16-leaf network; helpers take widths as arguments.
package pe_pkt_pkg;
    localparam int PKT_MAX_W      = 64;
    localparam int FIELD_MAX_W    = 16;
    localparam int DEF_NUM_LEAVES = 16;
    localparam int DEF_P_SZ       = 32;
    localparam int ADDR_W         = (DEF_NUM_LEAVES > 1) ? $clog2(DEF_NUM_LEAVES) : 1;
    localparam int VALID_BIT      = DEF_P_SZ - 1;
    localparam int ADDR_MSB       = VALID_BIT - 1;
    localparam int ADDR_LSB       = ADDR_MSB - ADDR_W + 1;
    localparam int SEQ_MSB        = ADDR_LSB - 1;
    localparam int SEQ_LSB        = SEQ_MSB - ADDR_W + 1;
    localparam int DATA_MSB       = SEQ_LSB - 1;

    function automatic int addr_width(input int num_leaves);
        return (num_leaves > 1) ? $clog2(num_leaves) : 1;
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] field_mask(input int w);
        logic [FIELD_MAX_W-1:0] m;
        m = '1;
        return m >> (FIELD_MAX_W - w);
    endfunction

    // Address sits directly below the valid bit.
    function automatic logic [FIELD_MAX_W-1:0] pkt_addr(input logic [PKT_MAX_W-1:0] pkt,
                                                        input int p_sz, input int addr_w);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (p_sz - 1 - addr_w);
        return sh[FIELD_MAX_W-1:0] & field_mask(addr_w);
    endfunction

    function automatic logic [FIELD_MAX_W-1:0] pkt_seq(input logic [PKT_MAX_W-1:0] pkt,
                                                       input int p_sz, input int addr_w);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (p_sz - 1 - 2 * addr_w);
        return sh[FIELD_MAX_W-1:0] & field_mask(addr_w);
    endfunction
endpackage

// File: rtl/pe_sink_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; rd_data is 0 when empty.
// Latency: a push is visible on rd_data the cycle after the write edge.
// Backpressure: push while full is accepted only alongside a real pop; pop while empty is ignored.
module pe_sink_fifo #(
    parameter int DW    = 31,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wr_data,
    output logic [DW-1:0]          rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/pe_sink.sv
// Leaf receiver: checks address/sequence of BFT packets and queues accepted ones for the host.
// Latency: 2 edges from interface_pe to out_valid (capture, then FIFO write).
// Backpressure: out_valid/out_ready pop; packets arriving to a full FIFO without a pop are dropped. PE_SINK_WATERMARK_EN adds max_level.
module pe_sink #(
    parameter int NUM_LEAVES = 16,
    parameter int P_SZ       = 32,
    parameter int LEAF_ADDR  = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [P_SZ-1:0]             interface_pe,
    output logic [P_SZ-2:0]             out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    input  logic                        clear_stats,
    output logic [CNT_W-1:0]            drop_cnt,
    output logic [CNT_W-1:0]            seq_err_cnt,
    output logic [CNT_W-1:0]            misroute_cnt
`ifdef PE_SINK_WATERMARK_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] max_level
`endif
);
    import pe_pkt_pkg::*;

    localparam int ADDR_W = addr_width(NUM_LEAVES);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [P_SZ-1:0]   in_q;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] in_seq;
    logic [ADDR_W-1:0] exp_seq;
    logic              seq_synced;
    logic              addr_hit;
    logic              misroute;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;

    assign in_addr   = ADDR_W'(pkt_addr(PKT_MAX_W'(in_q), P_SZ, ADDR_W));
    assign in_seq    = ADDR_W'(pkt_seq(PKT_MAX_W'(in_q), P_SZ, ADDR_W));
    assign addr_hit  = in_q[P_SZ-1] & (in_addr == ADDR_W'(LEAF_ADDR));
    assign misroute  = in_q[P_SZ-1] & (in_addr != ADDR_W'(LEAF_ADDR));
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = addr_hit & (~fifo_full | pop);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= '0;
        end else if (interface_pe[P_SZ-1]) begin
            in_q <= interface_pe;
        end else begin
            in_q[P_SZ-1] <= 1'b0;
        end
    end

    // Sequence tracking runs on every address match, including packets dropped for space.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt     <= '0;
            seq_err_cnt  <= '0;
            misroute_cnt <= '0;
            seq_synced   <= 1'b0;
            exp_seq      <= '0;
        end else if (clear_stats) begin
            drop_cnt     <= '0;
            seq_err_cnt  <= '0;
            misroute_cnt <= '0;
            seq_synced   <= 1'b0;
        end else begin
            if (misroute) misroute_cnt <= sat_inc(misroute_cnt);
            if (addr_hit) begin
                if (!push) drop_cnt <= sat_inc(drop_cnt);
                if (seq_synced && (in_seq != exp_seq)) seq_err_cnt <= sat_inc(seq_err_cnt);
                seq_synced <= 1'b1;
                exp_seq    <= in_seq + 1'b1;
            end
        end
    end

    pe_sink_fifo #(
        .DW    (P_SZ - 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (in_q[P_SZ-2:0]),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef PE_SINK_WATERMARK_EN
    logic [LVL_W-1:0] level_nxt;

    assign level_nxt = fifo_count + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_level <= '0;
        end else if (clear_stats) begin
            max_level <= '0;
        end else if (level_nxt > max_level) begin
            max_level <= level_nxt;
        end
    end
`endif
endmodule
